mem_port_arbiter: RTL and testbench

- Sequences and shares the single-ported, variable-latency unified memory between two requesters: the multicycle CPU's instruction fetch (IF state) and data access (MEM state, LWD/SWD).
- Sits between the control unit/datapath and the memory model.
- Registers all memory-side strobes, holds each access until the memory signals completion, and returns a one-cycle acknowledge carrying read data.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_f;
    logic [ADDR_W-1:0] addr_f;
    logic              req_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              ack_f;
    logic              ack_d;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              err;

    modport slave (
        input  req_f, addr_f, req_d, we_d, addr_d, wdata_d, mem_ready, mem_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, ack_f, ack_d, rdata, busy, err
    );

    modport master (
        output req_f, addr_f, req_d, we_d, addr_d, wdata_d, mem_ready, mem_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, ack_f, ack_d, rdata, busy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported variable-latency memory
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACC_F, ACC_D, RESP} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_mem_read, w_mem_read_nxt;
    logic              r_mem_write, w_mem_write_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_ack_f, w_ack_f_nxt;
    logic              r_ack_d, w_ack_d_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_busy;
    logic              r_err, w_err_nxt;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  r_wait, w_wait_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ack_f     <= 1'b0;
            r_ack_d     <= 1'b0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_wait      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_ack_f     <= w_ack_f_nxt;
            r_ack_d     <= w_ack_d_nxt;
            r_rdata     <= w_rdata_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_err       <= w_err_nxt;
`ifdef MEM_TIMEOUT_EN
            r_wait      <= w_wait_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_ack_f_nxt     = 1'b0;
        w_ack_d_nxt     = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_err_nxt       = r_err;
`ifdef MEM_TIMEOUT_EN
        w_wait_nxt      = '0;
`endif
        case (r_state)
            IDLE: begin
                // Data wins over fetch so an in-flight instruction can retire.
                if (bus.req_d) begin
                    w_state_nxt     = ACC_D;
                    w_mem_addr_nxt  = bus.addr_d;
                    w_mem_wdata_nxt = bus.wdata_d;
                    w_mem_write_nxt = bus.we_d;
                    w_mem_read_nxt  = ~bus.we_d;
                end else if (bus.req_f) begin
                    w_state_nxt     = ACC_F;
                    w_mem_addr_nxt  = bus.addr_f;
                    w_mem_read_nxt  = 1'b1;
                end
            end
            ACC_F, ACC_D: begin
                if (bus.mem_ready) begin
                    if (r_mem_read)
                        w_rdata_nxt = bus.mem_rdata;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_ack_f_nxt     = (r_state == ACC_F);
                    w_ack_d_nxt     = (r_state == ACC_D);
                    w_state_nxt     = RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (r_wait == CNT_W'(TIMEOUT - 1)) begin
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_ack_f_nxt     = (r_state == ACC_F);
                    w_ack_d_nxt     = (r_state == ACC_D);
                    w_rdata_nxt     = '0;
                    w_err_nxt       = 1'b1;
                    w_state_nxt     = RESP;
                end else begin
                    w_wait_nxt      = r_wait + 1'b1;
                end
`endif
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.ack_f     = r_ack_f;
    assign bus.ack_d     = r_ack_d;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_f     = 1'b0;
        bus.addr_f    = '0;
        bus.req_d     = 1'b0;
        bus.we_d      = 1'b0;
        bus.addr_d    = '0;
        bus.wdata_d   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_read",  bus.mem_read,  0);
        check("rst_write", bus.mem_write, 0);
        check("rst_addr",  bus.mem_addr,  0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_acks",  {bus.ack_f, bus.ack_d}, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_busy",  bus.busy,  0);
        check("rst_err",   bus.err,   0);
        reset_n = 1'b1;
        tick();
        check("idle_busy", bus.busy, 0);

        // fetch with two wait cycles
        bus.req_f = 1'b1; bus.addr_f = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("f_read",  bus.mem_read, 1);
            check("f_addr",  bus.mem_addr, 16'h0010);
            check("f_noack", {bus.ack_f, bus.ack_d}, 0);
            check("f_busy",  bus.busy, 1);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h6A05;
        tick();
        check("f_ack",   bus.ack_f, 1);
        check("f_ackd",  bus.ack_d, 0);
        check("f_rdata", bus.rdata, 16'h6A05);
        check("f_rdrop", bus.mem_read, 0);
        bus.req_f = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 16'hFFFF;
        tick();
        check("f_ack_end", bus.ack_f, 0);
        check("f_idle",    bus.busy, 0);

        // store, zero wait
        bus.req_d = 1'b1; bus.we_d = 1'b1; bus.addr_d = 16'h00C0; bus.wdata_d = 16'h1234;
        tick();
        check("s_write", bus.mem_write, 1);
        check("s_read",  bus.mem_read, 0);
        check("s_addr",  bus.mem_addr, 16'h00C0);
        check("s_wdata", bus.mem_wdata, 16'h1234);
        bus.mem_ready = 1'b1;
        tick();
        check("s_ack",   {bus.ack_f, bus.ack_d}, 2'b01);
        check("s_wdrop", bus.mem_write, 0);
        check("s_rkeep", bus.rdata, 16'h6A05);
        bus.req_d = 1'b0; bus.mem_ready = 1'b0;
        tick();
        check("s_ack_end", bus.ack_d, 0);

        // load back the stored word
        bus.req_d = 1'b1; bus.we_d = 1'b0;
        tick();
        check("l_read",  bus.mem_read, 1);
        check("l_write", bus.mem_write, 0);
        check("l_addr",  bus.mem_addr, 16'h00C0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h1234;
        tick();
        check("l_ack",   bus.ack_d, 1);
        check("l_rdata", bus.rdata, 16'h1234);
        bus.req_d = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // simultaneous requests: data first, then fetch
        bus.req_f = 1'b1; bus.addr_f = 16'h0020;
        bus.req_d = 1'b1; bus.we_d = 1'b0; bus.addr_d = 16'h0030;
        tick();
        check("p_addr_d", bus.mem_addr, 16'h0030);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'hBEEF;
        tick();
        check("p_ack_d", {bus.ack_f, bus.ack_d}, 2'b01);
        check("p_rd_d",  bus.rdata, 16'hBEEF);
        bus.req_d = 1'b0; bus.mem_ready = 1'b0;
        tick();
        check("p_gap_busy", bus.busy, 0);
        check("p_gap_read", bus.mem_read, 0);
        tick();
        check("p_addr_f", bus.mem_addr, 16'h0020);
        check("p_read_f", bus.mem_read, 1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h5555;
        tick();
        check("p_ack_f", {bus.ack_f, bus.ack_d}, 2'b10);
        check("p_rd_f",  bus.rdata, 16'h5555);
        bus.req_f = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // reset in the middle of a store
        bus.req_d = 1'b1; bus.we_d = 1'b1; bus.addr_d = 16'h0040; bus.wdata_d = 16'hAAAA;
        tick();
        check("r_write", bus.mem_write, 1);
        reset_n = 1'b0; bus.req_d = 1'b0;
        tick();
        check("r_strobes", {bus.mem_read, bus.mem_write}, 0);
        check("r_acks",    {bus.ack_f, bus.ack_d}, 0);
        check("r_busy",    bus.busy, 0);
        check("r_addr",    bus.mem_addr, 0);
        reset_n = 1'b1;
        bus.req_f = 1'b1; bus.addr_f = 16'h0050;
        tick();
        check("r_f_read", bus.mem_read, 1);
        check("r_f_addr", bus.mem_addr, 16'h0050);
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h1111;
        tick();
        check("r_f_ack",   bus.ack_f, 1);
        check("r_f_rdata", bus.rdata, 16'h1111);
        bus.req_f = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // stale fetch request held one cycle past the ack
        bus.req_f = 1'b1; bus.addr_f = 16'h0060;
        tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h2222;
        tick();
        check("st_ack1", bus.ack_f, 1);
        bus.mem_ready = 1'b0;
        tick();
        check("st_ack_lo", bus.ack_f, 0);
        check("st_idle",   bus.busy, 0);
        tick();
        check("st_reacc", bus.mem_read, 1);
        check("st_addr",  bus.mem_addr, 16'h0060);
        bus.req_f = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_noack", bus.ack_f, 0);
            check("st_busy",  bus.busy, 1);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 16'h3333;
        tick();
        check("st_ack2",  bus.ack_f, 1);
        check("st_rdata", bus.rdata, 16'h3333);
        bus.mem_ready = 1'b0;
        tick();
        tick();
        check("st_done", {bus.busy, bus.mem_read, bus.ack_f}, 0);

`ifdef MEM_TIMEOUT_EN
        bus.req_f = 1'b1; bus.addr_f = 16'h0070;
        tick();
        bus.req_f = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            check("to_wait_read", bus.mem_read, 1);
            check("to_wait_ack",  bus.ack_f, 0);
        end
        tick();
        check("to_ack",   bus.ack_f, 1);
        check("to_read",  bus.mem_read, 0);
        check("to_rdata", bus.rdata, 0);
        check("to_err",   bus.err, 1);
        tick();
        check("to_ack_lo", bus.ack_f, 0);
        check("to_err_hold", bus.err, 1);
        tick();
        check("to_err_idle", bus.err, 1);
        reset_n = 1'b0;
        tick();
        check("to_err_rst", bus.err, 0);
        reset_n = 1'b1;
`else
        bus.req_f = 1'b1; bus.addr_f = 16'h0070;
        tick();
        bus.req_f = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("nto_read", bus.mem_read, 1);
        check("nto_ack",  bus.ack_f, 0);
        check("nto_err",  bus.err, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
